dma_pkt_writer: RTL
===================

Name: dma_pkt_writer

Overview:
- Downstream consumer of the 17-bit, 8-entry length/flag register FIFO in the DMA path.
- Each FIFO entry describes one received packet; its payload waits in a companion 32-bit data FIFO.
- For each entry, the block writes the payload words into a ring-buffer packet memory, or discards them when the drop flag is set.
- It then emits one completion descriptor (start address, byte length) toward the CPU-side DMA control.
- It tracks free ring space so it never overwrites unreleased packets.

Parameters:
- ADDR_W, 10, word-address width of packet ring memory; ring depth = 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  core clock.
- srst  in  1  synchronous active-high reset.
- i_len_empty  in  1  length FIFO empty.
- i_len_dout  in  17  show-ahead head entry; [16]=drop flag, [15:0]=packet byte length.
- o_len_rd  out  1  pop length FIFO.
- i_data_empty  in  1  data FIFO empty.
- i_data_dout  in  32  show-ahead head data word.
- o_data_rd  out  1  pop data FIFO.
- o_mem_wren  out  1  packet memory write strobe.
- o_mem_addr  out  ADDR_W  word write address.
- o_mem_wdata  out  32  write data.
- o_pkt_valid  out  1  completion descriptor valid.
- o_pkt_addr  out  ADDR_W  word address of the packet's first word.
- o_pkt_len  out  16  packet byte length.
- i_pkt_ready  in  1  descriptor accepted.
- i_free_inc  in  1  consumer releases ring words this cycle.
- i_free_num  in  ADDR_W+1  number of words released.
- o_stat_pkt_cnt  out  32  statistics: written packets.
- o_stat_drop_cnt  out  32  statistics: dropped packets.

Behaviour:
- Reset (srst sampled high at a clk edge):
  - State=IDLE; all outputs 0.
  - Write pointer=0; free_cnt=2^ADDR_W.
  - Reset mid-packet abandons the packet. No descriptor is issued. The FIFOs are reset by the same srst.
- Word count: words = (len+3)>>2, 15 bits, computed combinationally from i_len_dout[15:0].
- IDLE:
  - Pop the head entry (o_len_rd=1 for exactly one cycle) when !i_len_empty and any of:
    - flag=1;
    - len=0;
    - words<=free_cnt.
  - Otherwise hold; o_len_rd=0. There is no head-of-line bypass.
  - On pop, latch len, flag, start=wr_ptr, rem=words.
  - Next state:
    - len=0 → DONE if flag=0, else IDLE.
    - flag=1 → DROP.
    - Otherwise → WRITE, and free_cnt -= words in that same cycle.
- WRITE:
  - Each cycle with !i_data_empty: o_data_rd=1 combinationally.
  - Next cycle: registered o_mem_wren=1, o_mem_addr=wr_ptr, o_mem_wdata=the popped word.
  - wr_ptr increments modulo 2^ADDR_W, wrapping to 0 after 2^ADDR_W-1.
  - rem decrements per popped word.
  - Pop with rem=1 → DONE.
  - Empty data FIFO stalls with no write.
- DROP:
  - Pops data words identically to WRITE, but o_mem_wren stays 0 and wr_ptr is unchanged.
  - Last pop → IDLE; no descriptor.
- DONE:
  - o_pkt_valid rises exactly 1 cycle after the final o_mem_wren pulse (for len=0, the cycle after the pop).
  - o_pkt_addr=start; o_pkt_len=len.
  - All three are held stable until i_pkt_ready=1 is sampled, then → IDLE.
  - i_pkt_ready may be high before valid.
- free_cnt:
  - Add i_free_num when i_free_inc=1.
  - A simultaneous pop-subtract and release-add are both applied in the same cycle.
  - The result is clamped to 2^ADDR_W.
- Throughput: one word per cycle sustained.
- Gaps: minimum 1 IDLE cycle between packets, plus the DONE handshake.

Optional Feature:
- Macro DMA_PKT_WR_STAT_EN.
- Defined:
  - o_stat_pkt_cnt increments on each accepted descriptor (o_pkt_valid && i_pkt_ready).
  - o_stat_drop_cnt increments on each pop with flag=1.
  - Both are 32-bit, wrap at 2^32, and are cleared by srst.
- Undefined: both ports are tied to 0 and no counter logic is instantiated.

Decomposition:
- Shared package dma_pkg:
  - Entry-field constants: LEN_FLAG_BIT=16, LEN_MSB=15.
  - FSM state encoding: IDLE, WRITE, DROP, DONE.
  - Word-count function.
- Natural sub-module: dma_ring_credit (free_cnt tracking with clamp), instantiated once.

Test Plan:
- Entry {0,16'd10}, data A,B,C, ring empty → o_len_rd 1 cycle; writes addr 0,1,2 with A,B,C; next cycle o_pkt_valid with addr=0, len=10; free_cnt=1021.
- Entry {1,16'd8}, 2 data words → both words popped, no o_mem_wren, no descriptor, wr_ptr unchanged, stat_drop_cnt+1 when enabled.
- wr_ptr=1022, len=12 → writes at 1022,1023,0; descriptor addr=1022.
- free_cnt=2, head len=16 (4 words) → no pop; then i_free_inc with i_free_num=2 → pop the next cycle.
- Data FIFO empty for 3 cycles mid-packet; i_pkt_ready low for 5 cycles → write stalls with no extra strobes; descriptor held stable for 5 cycles, then accepted.
- srst asserted during WRITE after 2 of 4 words → all outputs 0, free_cnt=1024, no descriptor; a new packet then writes from addr 0.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg : shared entry-field constants, FSM encoding and word-count helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dma_pkg;

  localparam int LEN_FLAG_BIT = 16;
  localparam int LEN_MSB      = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte length rounded up to whole 32-bit words.
  function automatic logic [14:0] word_count(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'd3;
    return sum[16:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_ring_credit.sv
// ---------------------------------------------------------------------------
// dma_ring_credit : free-word counter for the packet ring, clamped to depth
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_ring_credit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_sub_en,
  input  logic [ADDR_W:0]   i_sub_num,
  input  logic              i_inc_en,
  input  logic [ADDR_W:0]   i_inc_num,
  output logic [ADDR_W:0]   o_free_cnt
);

  localparam logic [ADDR_W+1:0] C_FULL = {2'b01, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   r_free_cnt;
  logic [ADDR_W+1:0] w_add;
  logic [ADDR_W+1:0] w_sub;
  logic [ADDR_W+1:0] w_sum;

  // Subtract never exceeds the current count, so only the upper bound needs a clamp.
  always_comb begin
    w_add = i_inc_en ? {1'b0, i_inc_num} : '0;
    w_sub = i_sub_en ? {1'b0, i_sub_num} : '0;
    w_sum = {1'b0, r_free_cnt} + w_add - w_sub;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_free_cnt <= C_FULL[ADDR_W:0];
    end else if (w_sum > C_FULL) begin
      r_free_cnt <= C_FULL[ADDR_W:0];
    end else begin
      r_free_cnt <= w_sum[ADDR_W:0];
    end
  end

  assign o_free_cnt = r_free_cnt;

endmodule

`default_nettype wire

// File: rtl/dma_pkt_writer.sv
// ---------------------------------------------------------------------------
// dma_pkt_writer : drains length/data FIFOs into a packet ring, emits descriptors
// Optional statistics counters enabled by `define DMA_PKT_WR_STAT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_pkt_writer
  import dma_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_len_empty,
  input  logic [16:0]       i_len_dout,
  output logic              o_len_rd,
  input  logic              i_data_empty,
  input  logic [31:0]       i_data_dout,
  output logic              o_data_rd,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_pkt_valid,
  output logic [ADDR_W-1:0] o_pkt_addr,
  output logic [15:0]       o_pkt_len,
  input  logic              i_pkt_ready,
  input  logic              i_free_inc,
  input  logic [ADDR_W:0]   i_free_num,
  output logic [31:0]       o_stat_pkt_cnt,
  output logic [31:0]       o_stat_drop_cnt
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_start;
  logic [15:0]       r_len;
  logic [14:0]       r_rem;

  logic              w_flag;
  logic              w_zero;
  logic              w_fits;
  logic [14:0]       w_words;
  logic [CNT_W-1:0]  w_sub_num;
  logic [CNT_W-1:0]  w_free_cnt;
  logic              w_pop_len;
  logic              w_to_write;
  logic              w_data_pop;

  always_comb begin
    w_flag     = i_len_dout[LEN_FLAG_BIT];
    w_zero     = (i_len_dout[LEN_MSB:0] == 16'd0);
    w_words    = word_count(i_len_dout[LEN_MSB:0]);
    w_fits     = (32'(w_words) <= 32'(w_free_cnt));
    w_sub_num  = CNT_W'(w_words);
    w_pop_len  = !srst && (r_state == IDLE) && !i_len_empty && (w_flag || w_zero || w_fits);
    w_to_write = w_pop_len && !w_flag && !w_zero;
    w_data_pop = !srst && ((r_state == WRITE) || (r_state == DROP)) && !i_data_empty;
  end

  assign o_len_rd  = w_pop_len;
  assign o_data_rd = w_data_pop;

  dma_ring_credit #(
    .ADDR_W (ADDR_W)
  ) u_credit (
    .clk        (clk),
    .srst       (srst),
    .i_sub_en   (w_to_write),
    .i_sub_num  (w_sub_num),
    .i_inc_en   (i_free_inc),
    .i_inc_num  (i_free_num),
    .o_free_cnt (w_free_cnt)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_start     <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      o_mem_wren  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt_addr  <= '0;
      o_pkt_len   <= '0;
    end else begin
      o_mem_wren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop_len) begin
            r_len   <= i_len_dout[LEN_MSB:0];
            r_start <= r_wr_ptr;
            r_rem   <= w_words;
            if (w_zero) begin
              // Empty packets have no write phase, so the descriptor goes out at once.
              if (!w_flag) begin
                r_state     <= DONE;
                o_pkt_valid <= 1'b1;
                o_pkt_addr  <= r_wr_ptr;
                o_pkt_len   <= i_len_dout[LEN_MSB:0];
              end
            end else if (w_flag) begin
              r_state <= DROP;
            end else begin
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (w_data_pop) begin
            o_mem_wren  <= 1'b1;
            o_mem_addr  <= r_wr_ptr;
            o_mem_wdata <= i_data_dout;
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_rem       <= r_rem - 15'd1;
            if (r_rem == 15'd1) begin
              r_state <= DONE;
            end
          end
        end
        DROP: begin
          if (w_data_pop) begin
            r_rem <= r_rem - 15'd1;
            if (r_rem == 15'd1) begin
              r_state <= IDLE;
            end
          end
        end
        DONE: begin
          if (o_pkt_valid && i_pkt_ready) begin
            o_pkt_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
            o_pkt_valid <= 1'b1;
            o_pkt_addr  <= r_start;
            o_pkt_len   <= r_len;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DMA_PKT_WR_STAT_EN
  logic [31:0] r_stat_pkt;
  logic [31:0] r_stat_drop;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_stat_pkt  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (o_pkt_valid && i_pkt_ready) begin
        r_stat_pkt <= r_stat_pkt + 32'd1;
      end
      if (w_pop_len && w_flag) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign o_stat_pkt_cnt  = r_stat_pkt;
  assign o_stat_drop_cnt = r_stat_drop;
`else
  assign o_stat_pkt_cnt  = '0;
  assign o_stat_drop_cnt = '0;
`endif

endmodule

`default_nettype wire
